// File: rtl/gen_tx_msg_if.sv
// gen_tx_msg_if
// Bundles the message request, data-source handshake and encoder-facing
// signals of the 1553 transmit message sequencer.
//
// master : the side that requests messages and supplies data words
//          (drives st, abort, cw, dw_cnt, nodw, dw_in)
// slave  : the sequencer itself
//          (drives dw_rd, txen, DAT, sync_cw, word_st, word_idx, busy, done)
interface gen_tx_msg_if;
    logic        st;
    logic        abort;
    logic [15:0] cw;
    logic [4:0]  dw_cnt;
    logic        nodw;
    logic [15:0] dw_in;
    logic        dw_rd;
    logic        txen;
    logic [15:0] DAT;
    logic        sync_cw;
    logic        word_st;
    logic [5:0]  word_idx;
    logic        busy;
    logic        done;

    modport master (
        output st, abort, cw, dw_cnt, nodw, dw_in,
        input  dw_rd, txen, DAT, sync_cw, word_st, word_idx, busy, done
    );

    modport slave (
        input  st, abort, cw, dw_cnt, nodw, dw_in,
        output dw_rd, txen, DAT, sync_cw, word_st, word_idx, busy, done
    );
endinterface

// File: rtl/gen_tx_msg.sv
// gen_tx_msg
// MIL-STD-1553 transmit message sequencer. A start pulse launches one
// command/status word slot followed by 0..32 data-word slots, each
// WORD_CLKS cycles long and back to back. Data words are pulled one at a
// time from a show-ahead source using a one-cycle read strobe.
//
// Parameters:
//   WORD_CLKS : clocks per word slot (must be >= 2)
//   CNT_W     : slot counter width, 2**CNT_W >= WORD_CLKS
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : gen_tx_msg_if.slave (request inputs, data source, encoder outputs)
module gen_tx_msg #(
    parameter int WORD_CLKS = 1000,
    parameter int CNT_W     = 10
) (
    input  logic          clk,
    input  logic          rst,
    gen_tx_msg_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        CW,
        DW
    } state_t;

    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(WORD_CLKS - 1);
    localparam logic [CNT_W-1:0] SLOT_PRE  = CNT_W'(WORD_CLKS - 2);

    state_t           state;
    logic [CNT_W-1:0] cb;
    logic [5:0]       rem;

    logic        dw_rd;
    logic        txen;
    logic [15:0] dat;
    logic        sync_cw;
    logic        word_st;
    logic [5:0]  word_idx;
    logic        busy;
    logic        done;

    assign bus.dw_rd    = dw_rd;
    assign bus.txen     = txen;
    assign bus.DAT      = dat;
    assign bus.sync_cw  = sync_cw;
    assign bus.word_st  = word_st;
    assign bus.word_idx = word_idx;
    assign bus.busy     = busy;
    assign bus.done     = done;

    // Single sequencer process. All outputs are registered, so the read
    // strobe is raised one cycle early (at the second-to-last slot cycle)
    // to be high during the last cycle of the slot, the cycle on whose
    // closing edge dw_in is captured into DAT. In IDLE, st is only taken
    // once busy has dropped, so the done cycle cannot retrigger.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cb       <= '0;
            rem      <= '0;
            dw_rd    <= 1'b0;
            txen     <= 1'b0;
            dat      <= 16'h0000;
            sync_cw  <= 1'b0;
            word_st  <= 1'b0;
            word_idx <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            word_st <= 1'b0;
            dw_rd   <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (bus.st && !bus.abort && !busy) begin
                        state    <= CW;
                        cb       <= '0;
                        dat      <= bus.cw;
                        txen     <= 1'b1;
                        busy     <= 1'b1;
                        word_st  <= 1'b1;
                        sync_cw  <= 1'b1;
                        word_idx <= '0;
                        if (bus.nodw)
                            rem <= 6'd0;
                        else if (bus.dw_cnt == 5'd0)
                            rem <= 6'd32;
                        else
                            rem <= {1'b0, bus.dw_cnt};
                    end
                end
                CW, DW: begin
                    if (bus.abort) begin
                        state   <= IDLE;
                        cb      <= '0;
                        txen    <= 1'b0;
                        busy    <= 1'b0;
                        sync_cw <= 1'b0;
                    end else if (cb == SLOT_LAST) begin
                        cb      <= '0;
                        sync_cw <= 1'b0;
                        if (rem != 6'd0) begin
                            state    <= DW;
                            dat      <= bus.dw_in;
                            rem      <= rem - 6'd1;
                            word_idx <= word_idx + 6'd1;
                            word_st  <= 1'b1;
                        end else begin
                            state <= IDLE;
                            txen  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        cb <= cb + 1'b1;
                        if (cb == SLOT_PRE && rem != 6'd0)
                            dw_rd <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gen_tx_msg.sv
// tb_gen_tx_msg
// Self-checking bench for gen_tx_msg with WORD_CLKS=10. A show-ahead
// source model feeds dw_in; the expected word stream of each message is
// queued when the message is launched and popped on every word_st.
module tb_gen_tx_msg;

    localparam int W = 10;

    typedef struct {
        logic [15:0] dat;
        logic [5:0]  idx;
        logic        sync;
    } exp_word_t;

    typedef struct {
        logic [15:0] cw;
        logic [4:0]  cnt;
        logic        nodw;
        logic [15:0] base;
        int          exp_txen;
        int          exp_reads;
    } msg_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    gen_tx_msg_if bus();

    gen_tx_msg #(.WORD_CLKS(W), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Show-ahead data source: dw_in is the word at the read pointer,
    // which advances on every edge where dw_rd is high.
    logic [15:0] src_mem [0:63];
    int          rd_ptr = 0;

    assign bus.dw_in = src_mem[rd_ptr[5:0]];

    always @(posedge clk) begin
        if (bus.dw_rd)
            rd_ptr <= rd_ptr + 1;
    end

    exp_word_t exp_q[$];
    msg_vec_t  vecs[4];

    int n_checks = 0;
    int n_errors = 0;

    int res_txen;
    int res_reads;
    int res_dones;
    int res_done_cyc;
    int res_left;
    int res_bad_rd;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Launches one message and follows it cycle by cycle until busy and
    // txen are both low. Cycle 1 is the cycle after the edge that samples
    // st. abort/rst/second-st are driven during the given cycle (0 = never).
    task automatic apply_stimulus(input logic [15:0] cw, input logic [4:0] cnt, input logic nodw,
                                  input logic [15:0] base, input int abort_cyc, input int rst_cyc,
                                  input int st2_cyc);
        int        n;
        bit        finished;
        exp_word_t e;
        n = nodw ? 0 : ((cnt == 5'd0) ? 32 : int'(cnt));
        exp_q.delete();
        e.dat = cw;
        e.idx = 6'd0;
        e.sync = 1'b1;
        exp_q.push_back(e);
        for (int k = 0; k < n; k++) begin
            src_mem[(rd_ptr + k) % 64] = base + 16'(k);
            e.dat = base + 16'(k);
            e.idx = 6'(k + 1);
            e.sync = 1'b0;
            exp_q.push_back(e);
        end
        res_txen = 0;
        res_reads = 0;
        res_dones = 0;
        res_done_cyc = 0;
        res_bad_rd = 0;
        finished = 1'b0;

        @(negedge clk);
        bus.st = 1'b1;
        bus.cw = cw;
        bus.dw_cnt = cnt;
        bus.nodw = nodw;

        for (int cyc = 1; cyc <= 400 && !finished; cyc++) begin
            @(negedge clk);
            bus.st = 1'b0;
            bus.abort = 1'b0;
            rst = 1'b0;
            if (cyc == 1)
                check_output("first_cycle", {bus.txen, bus.busy, bus.word_st, bus.sync_cw, bus.DAT},
                             {4'b1111, cw});
            if (bus.txen)
                res_txen++;
            if (bus.dw_rd) begin
                res_reads++;
                if (cyc % W != 0)
                    res_bad_rd++;
            end
            if (bus.done) begin
                res_dones++;
                res_done_cyc = cyc;
                check_output("done_busy_txen", {bus.busy, bus.txen}, 2'b10);
            end
            if (bus.word_st) begin
                if (exp_q.size() == 0) begin
                    check_output("extra_word_st", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_output("word_dat", bus.DAT, e.dat);
                    check_output("word_idx_sync", {bus.word_idx, bus.sync_cw}, {e.idx, e.sync});
                end
            end
            if (rst_cyc != 0 && cyc == rst_cyc + 1)
                check_output("after_rst_zero",
                             {bus.txen, bus.dw_rd, bus.sync_cw, bus.word_st, bus.busy, bus.done,
                              bus.word_idx, bus.DAT}, 0);
            if (abort_cyc != 0 && cyc == abort_cyc + 1)
                check_output("after_abort", {bus.txen, bus.busy, bus.done}, 3'b000);
            if (cyc == abort_cyc)
                bus.abort = 1'b1;
            if (cyc == rst_cyc)
                rst = 1'b1;
            if (cyc == st2_cyc) begin
                bus.st = 1'b1;
                bus.cw = 16'hBBBB;
                bus.dw_cnt = 5'd7;
                bus.nodw = 1'b0;
            end
            if (!bus.busy && !bus.txen && !bus.st && !bus.abort && !rst)
                finished = 1'b1;
        end
        if (!finished)
            check_output("timeout", 0, 1);
        res_left = exp_q.size();
        exp_q.delete();
    endtask

    // Checks a message that ran to normal completion.
    task automatic check_normal(input string name, input int exp_txen, input int exp_reads);
        check_output({name, "_txen"}, res_txen, exp_txen);
        check_output({name, "_reads"}, res_reads, exp_reads);
        check_output({name, "_dones"}, res_dones, 1);
        check_output({name, "_done_cyc"}, res_done_cyc, exp_txen + 1);
        check_output({name, "_words_left"}, res_left, 0);
        check_output({name, "_rd_slot"}, res_bad_rd, 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++)
            src_mem[i] = 16'h0000;
        bus.st = 1'b0;
        bus.abort = 1'b0;
        bus.cw = 16'h0000;
        bus.dw_cnt = 5'd0;
        bus.nodw = 1'b0;

        vecs[0] = '{cw: 16'hDEF0, cnt: 5'd1, nodw: 1'b0, base: 16'h2233, exp_txen: 20,  exp_reads: 1};
        vecs[1] = '{cw: 16'hA5A5, cnt: 5'd5, nodw: 1'b1, base: 16'h0100, exp_txen: 10,  exp_reads: 0};
        vecs[2] = '{cw: 16'h1234, cnt: 5'd0, nodw: 1'b0, base: 16'h0001, exp_txen: 330, exp_reads: 32};
        vecs[3] = '{cw: 16'h0F0F, cnt: 5'd3, nodw: 1'b0, base: 16'h0100, exp_txen: 40,  exp_reads: 3};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_output("reset_state",
                     {bus.txen, bus.dw_rd, bus.sync_cw, bus.word_st, bus.busy, bus.done,
                      bus.word_idx, bus.DAT}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            apply_stimulus(vecs[v].cw, vecs[v].cnt, vecs[v].nodw, vecs[v].base, 0, 0, 0);
            check_normal($sformatf("vec%0d", v), vecs[v].exp_txen, vecs[v].exp_reads);
        end

        // Abort in cycle 15 of a 3-DW message, then a normal message.
        apply_stimulus(16'h7777, 5'd3, 1'b0, 16'h0300, 15, 0, 0);
        check_output("abort_txen", res_txen, 15);
        check_output("abort_reads", res_reads, 1);
        check_output("abort_dones", res_dones, 0);
        check_output("abort_words_left", res_left, 2);
        apply_stimulus(vecs[0].cw, vecs[0].cnt, vecs[0].nodw, 16'h3344, 0, 0, 0);
        check_normal("post_abort", 20, 1);

        // Second st with a different cw during the CW slot is ignored.
        apply_stimulus(16'h4444, 5'd2, 1'b0, 16'h0500, 0, 0, 5);
        check_normal("retrigger", 30, 2);

        // Reset in cycle 7 of the CW slot, then a full message.
        apply_stimulus(16'h6666, 5'd2, 1'b0, 16'h0700, 0, 7, 0);
        check_output("rst_txen", res_txen, 7);
        check_output("rst_reads", res_reads, 0);
        check_output("rst_dones", res_dones, 0);
        check_output("rst_words_left", res_left, 2);
        apply_stimulus(16'h9999, 5'd2, 1'b0, 16'h0800, 0, 0, 0);
        check_normal("post_rst", 30, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gen_tx_msg.md
# gen_tx_msg

Parametrised MIL-STD-1553 transmit message sequencer for the bus controller / remote terminal transmit path. On a start pulse it holds the transmitter enable for one command/status word slot followed by 0..32 data-word slots, presents each 16-bit word on `DAT` to the Manchester encoder, and pulls data words one at a time from a show-ahead source (FIFO or register file). It replaces the fixed single-CW/single-DW, fixed-length enable generator with a configurable word count, slot length, abort and completion signalling.

## Interface
- `WORD_CLKS`, 1000: clocks per word slot (20 µs at 50 MHz clk; 20 bit times of 1 µs).
- `CNT_W`, 10: width of slot counter; must satisfy 2^CNT_W ≥ WORD_CLKS.

- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `st` in 1: start pulse; sampled only in IDLE.
- `abort` in 1: synchronous abort; terminates a message in progress.
- `cw` in 16: command/status word; latched on the `st` edge.
- `dw_cnt` in 5: data-word count, latched on `st`; 0 encodes 32 (1553 convention).
- `nodw` in 1: latched on `st`; 1 = transmit CW slot only, `dw_cnt` ignored.
- `dw_in` in 16: next data word; must be valid at every edge where `dw_rd`=1.
- `dw_rd` out 1: one-cycle read strobe; `dw_in` captured on that same edge.
- `txen` out 1: transmitter enable.
- `DAT` out 16: word currently being transmitted.
- `sync_cw` out 1: 1 during the CW slot (encoder selects command/status sync), 0 during DW slots.
- `word_st` out 1: one-cycle pulse on the first cycle of every word slot.
- `word_idx` out 6: 0 during CW slot, k during k-th DW slot (1..32).
- `busy` out 1: 1 from the cycle after accepted `st` until the cycle `done` pulses (inclusive).
- `done` out 1: one-cycle pulse on normal completion only.

## Operation
- States: IDLE, CW, DW.
- IDLE: `txen`=0, `busy`=0. `st`=1 (and `abort`=0) → latch `cw`, `dw_cnt`, `nodw`; next state CW; slot counter `cb`=0; remaining count `rem` = nodw ? 0 : (dw_cnt==0 ? 32 : dw_cnt).
- CW: `DAT`=latched cw, `sync_cw`=1, `word_idx`=0. `cb` increments each cycle 0..WORD_CLKS-1.
- At `cb`=WORD_CLKS-1 in CW or DW: if `rem`>0 → `dw_rd`=1 this cycle, `DAT`←`dw_in`, `rem`←`rem`-1, `word_idx`+1, `cb`←0, state DW; else → `txen`←0, `done`=1 on the following cycle, state IDLE.
- `st` while busy: ignored (no retrigger, no re-latch).
- `abort`=1 in CW/DW: next cycle `txen`=0, `busy`=0, state IDLE, no `done`, no further `dw_rd`. `abort` has priority over slot end and over `st`.
- `rst`=1: next cycle all outputs 0, `DAT`=16'h0000, state IDLE, counters 0; mid-message reset discards the message.
- Reset values: `txen`, `dw_rd`, `sync_cw`, `word_st`, `busy`, `done` = 0; `DAT`=0; `word_idx`=0.
- `DAT` holds its last value in IDLE until the next accepted `st`.

## Timing
- `st` high at edge E0 → cycle after E0: `txen`=1, `busy`=1, `word_st`=1, `sync_cw`=1, `DAT`=cw.
- Slot boundaries every WORD_CLKS cycles; `word_st` high in cycle 0 of each slot, simultaneous with new `DAT`.
- `dw_rd` high in last cycle of the preceding slot; at most one `dw_rd` per slot; exactly N reads per N-word message.
- `txen` high for exactly (1+N)·WORD_CLKS consecutive cycles (N=0 when nodw).
- `done` pulses in the first cycle with `txen`=0; `busy` falls the cycle after. A new `st` is accepted in the cycle after `busy` falls.
- No gaps between words (contiguous 1553 message).

## Test plan
- WORD_CLKS=10, cw=16'hDEF0, dw_cnt=1, dw_in=16'h2233 → txen high 20 cycles; DAT=DEF0 cycles 1–10, 2233 cycles 11–20; one dw_rd at cycle 10; sync_cw high 10 cycles; done at cycle 21.
- nodw=1, dw_cnt=5 → txen 10 cycles, zero dw_rd, word_idx stays 0, done once.
- dw_cnt=0, FIFO preloaded 1..32 → 32 dw_rd, txen 330 cycles, word_idx reaches 32, DAT sequence 1..32.
- abort asserted in cycle 15 of a 3-DW message → txen 0 next cycle, no done, exactly 1 dw_rd total, next st accepted normally.
- st re-pulsed mid-message with different cw → ignored; DAT/length unchanged.
- rst in cycle 7 of CW slot → all outputs 0 next cycle; subsequent st produces full correct message.
